// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - multi-cycle unsigned shift-and-add multiplier controller
//
// One WIDTH-bit ripple-carry adder is reused over WIDTH iterations, one
// partial product per cycle. The accumulator high half and the multiplier
// share a shift register: each cycle the sum shifts right into it, so after
// WIDTH iterations {acc, mplier} holds the full 2*WIDTH-bit product.
//
// Optional build macro: SHIFT_ADD_MUL_ZERO_BYPASS_EN
//   When defined, a zero a or b skips RUN and goes straight to DONE with
//   product 0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operands a/b valid
//   in_ready  controller can accept operands (IDLE only)
//   a         multiplicand, WIDTH bits, unsigned
//   b         multiplier, WIDTH bits, unsigned
//   out_valid product valid (DONE)
//   out_ready consumer accepts product
//   product   result a*b, 2*WIDTH bits, held until the next result
//   busy      high while iterating (RUN)

module shift_add_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic                 carry;

  // Ripple chain of full adders: sum = {1'b0, acc} + addend.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = '0;
    carry  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = acc_q[i] ^ addend[i] ^ carry;
      carry  = (acc_q[i] & addend[i]) | (carry & (acc_q[i] ^ addend[i]));
    end
    sum[WIDTH] = carry;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
          if (a == '0 || b == '0) begin
            state_d   = DONE;
            product_d = '0;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        busy = 1'b1;
        // Carry enters the accumulator MSB; sum LSB drops into the
        // multiplier MSB as its consumed LSB shifts out.
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        if (count_q == LAST) begin
          // Hold count at WIDTH-1 instead of wrapping past it.
          state_d   = DONE;
          product_d = {sum[WIDTH:1], sum[0], mplier_q[WIDTH-1:1]};
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - directed self-checking bench for shift_add_mul_ctrl (WIDTH=8)

module tb_shift_add_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int total_cnt;
  int pass_cnt;
  int cyc;

  shift_add_mul_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge while IDLE. Presents a/b for one cycle, scrambles
  // them afterwards, then expects out_valid exactly lat negedges after the
  // first negedge following acceptance (lat=8 for the full iteration path).
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input int lat, input logic [15:0] exp_prod);
    in_valid = 1'b1;
    a = av;
    b = bv;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~av;
    b = bv + 8'd5;
    if (lat > 0) begin
      check({tag, "_busy_run"}, busy, 1);
      check({tag, "_in_ready_run"}, in_ready, 0);
      for (int k = 1; k <= lat; k++) begin
        if (k == lat) begin
          check({tag, "_out_valid_early"}, out_valid, 0);
        end
        @(negedge clk);
      end
    end else begin
      check({tag, "_busy_bypass"}, busy, 0);
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_product"}, product, exp_prod);
    check({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  logic [7:0]  bb_a [3];
  logic [7:0]  bb_b [3];
  logic [15:0] bb_p [3];
  int          t_prev;
  int          seen;
  int          zero_lat;

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'd0;
    b         = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // 13*11 with immediate drain
    do_op("mul13x11", 8'd13, 8'd11, 8, 16'h008F);
    @(negedge clk);
    check("mul13x11_out_valid_drop", out_valid, 0);
    check("mul13x11_back_idle", in_ready, 1);

    // full-range result keeps the final carry
    do_op("mul255x255", 8'd255, 8'd255, 8, 16'hFE01);
    @(negedge clk);

    // backpressure: result held, new operands ignored
    out_ready = 1'b0;
    do_op("mul200x3", 8'd200, 8'd3, 8, 16'h0258);
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd7;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 16'h0258);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    do_op("mul7x7", 8'd7, 8'd7, 8, 16'h0031);
    @(negedge clk);

    // back-to-back with in_valid and out_ready held high
    bb_a[0] = 8'd1;   bb_b[0] = 8'd1;   bb_p[0] = 16'h0001;
    bb_a[1] = 8'd2;   bb_b[1] = 8'd128; bb_p[1] = 16'h0100;
    bb_a[2] = 8'd170; bb_b[2] = 8'd85;  bb_p[2] = 16'h3872;
    in_valid = 1'b1;
    a = bb_a[0];
    b = bb_b[0];
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      check("b2b_in_ready", in_ready, 1);
      if (i > 0) begin
        check("b2b_interval", cyc - t_prev, 10);
      end
      t_prev = cyc;
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      check("b2b_out_valid_seen", seen, 1);
      check("b2b_product", product, bb_p[i]);
      if (i < 2) begin
        a = bb_a[i+1];
        b = bb_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // reset during iteration 4 of 9*9
    in_valid = 1'b1;
    a = 8'd9;
    b = 8'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_out_valid", seen, 0);
    do_op("mul6x7", 8'd6, 8'd7, 8, 16'h002A);
    @(negedge clk);

    // zero operand
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
    zero_lat = 0;
`else
    zero_lat = 8;
`endif
    do_op("mul0x77", 8'd0, 8'd77, zero_lat, 16'h0000);
    @(negedge clk);
    check("mul0x77_back_idle", in_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
